// File: rtl/mem_ctrl_pkg.sv
// Shared codes for the byte-serial memory controller: request ops, length
// codes, FSM encoding and the arbitrated request bundle.
package mem_defs;

    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] MEM_BYTE  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_WORD  = 2'b11;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    typedef struct packed {
        logic        vld;
        src_t        src;
        logic [1:0]  op;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Reserved length code 2'b10 is served as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            MEM_BYTE: len_bytes = 3'd1;
            MEM_HALF: len_bytes = 3'd2;
            default:  len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Fixed-priority select between the MEM-stage and fetch ports; a MEM
// load/store always beats a fetch presented in the same cycle.
module mem_ctrl_arb
    import mem_defs::*;
(
    input  logic [1:0]  if_op,
    input  logic [1:0]  if_len,
    input  logic [31:0] if_addr,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output req_t        req
);

    always_comb begin
        req = '0;
        if (mem_op == MEM_LOAD || mem_op == MEM_STORE) begin
            req.vld   = 1'b1;
            req.src   = SRC_MEM;
            req.op    = mem_op;
            req.len   = mem_len;
            req.addr  = mem_addr;
            req.wdata = mem_wdata;
        end else if (if_op == MEM_LOAD) begin
            req.vld   = 1'b1;
            req.src   = SRC_IF;
            req.op    = MEM_LOAD;
            req.len   = if_len;
            req.addr  = if_addr;
            req.wdata = ZeroWord;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial controller: latches one request, walks it byte by byte over a
// byte-wide RAM, assembles loads little-endian and pulses the owner's rdy.
module mem_ctrl
    import mem_defs::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [1:0]  if_op,
    input  logic [1:0]  if_len,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_rdy,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    req_t        req;
    state_t      state_q, state_d;
    src_t        src_q;
    logic [2:0]  n_q, j_q, j_inc;
    logic [31:0] base_q, wdata_q, asm_q, asm_nxt;
    logic [31:0] ram_a_q, if_data_q, mem_rdata_q;
    logic [7:0]  ram_dout_q, wbyte_nxt;
    logic        ram_wr_q;

    mem_ctrl_arb u_arb (
        .if_op     (if_op),
        .if_len    (if_len),
        .if_addr   (if_addr),
        .mem_op    (mem_op),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .req       (req)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state_q <= ST_IDLE;
        else if (rdy_in)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req.vld) state_d = (req.op == MEM_STORE) ? ST_WRITE : ST_READ;
            ST_READ:  if (j_q == n_q) state_d = ST_DONE;
            ST_WRITE: if (j_q == n_q - 3'd1) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
        endcase
    end

    assign j_inc = j_q + 3'd1;

    // RAM data arrives one cycle after its address, so READ step j owns byte j-1.
    always_comb begin
        asm_nxt = asm_q;
        case (j_q)
            3'd1:    asm_nxt[7:0]   = ram_din;
            3'd2:    asm_nxt[15:8]  = ram_din;
            3'd3:    asm_nxt[23:16] = ram_din;
            3'd4:    asm_nxt[31:24] = ram_din;
            default: asm_nxt = asm_q;
        endcase
    end

    always_comb begin
        case (j_inc)
            3'd1:    wbyte_nxt = wdata_q[15:8];
            3'd2:    wbyte_nxt = wdata_q[23:16];
            3'd3:    wbyte_nxt = wdata_q[31:24];
            default: wbyte_nxt = 8'h00;
        endcase
    end

    // RAM-side registers are loaded one step ahead so that step j sees base + j.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            src_q       <= SRC_IF;
            n_q         <= 3'd0;
            j_q         <= 3'd0;
            base_q      <= ZeroWord;
            wdata_q     <= ZeroWord;
            asm_q       <= ZeroWord;
            ram_a_q     <= ZeroWord;
            ram_dout_q  <= 8'h00;
            ram_wr_q    <= 1'b0;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (req.vld) begin
                        src_q      <= req.src;
                        n_q        <= len_bytes(req.len);
                        j_q        <= 3'd0;
                        base_q     <= req.addr;
                        wdata_q    <= req.wdata;
                        asm_q      <= ZeroWord;
                        ram_a_q    <= req.addr;
                        ram_dout_q <= req.wdata[7:0];
                        ram_wr_q   <= (req.op == MEM_STORE);
                    end
                end
                ST_READ: begin
                    asm_q <= asm_nxt;
                    j_q   <= j_inc;
                    if (j_inc < n_q)
                        ram_a_q <= base_q + {29'd0, j_inc};
                    if (j_q == n_q) begin
                        if (src_q == SRC_IF)
                            if_data_q <= asm_nxt;
                        else
                            mem_rdata_q <= asm_nxt;
                    end
                end
                ST_WRITE: begin
                    j_q <= j_inc;
                    if (j_inc < n_q) begin
                        ram_a_q    <= base_q + {29'd0, j_inc};
                        ram_dout_q <= wbyte_nxt;
                        ram_wr_q   <= 1'b1;
                    end else begin
                        ram_wr_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                end
            endcase
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q & rdy_in;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_rdy    = rdy_in && (state_q == ST_DONE) && (src_q == SRC_IF);
    assign mem_rdy   = rdy_in && (state_q == ST_DONE) && (src_q == SRC_MEM);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM environment, a sparse shadow
// memory as reference, and a monitor that matches every rdy pulse and RAM write.
module tb_mem_ctrl;
    import mem_defs::*;

    logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1;
    logic [1:0]  if_op = MEM_NOP, if_len = MEM_BYTE, mem_op = MEM_NOP, mem_len = MEM_BYTE;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic        if_rdy, mem_rdy, ram_wr;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_op(if_op), .if_len(if_len), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .mem_op(mem_op), .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_if;
        bit          is_load;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t        sb[$];
    wr_t         wq[$];
    logic [7:0]  ref_mem [logic [31:0]];
    int          cyc = 0, checks = 0, errors = 0;
    logic [31:0] mdl_if_data = '0, mdl_mem_rdata = '0;

    // RAM environment; aliased on addr[11:0], frozen along with the block when rdy_in is low.
    bit   [7:0]  ram [4096];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a = '0;
    logic [7:0]  pre_d = '0;
    always @(posedge clk_in) begin
        if (rdy_in) ram_din <= ram[ram_a[11:0]];
        if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        if (pre_we) ram[pre_a] <= pre_d;
    end

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Monitor: every rdy pulse and every RAM write must match the oldest expectation.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk_in);
            if (!rdy_in)
                chk("stall_quiet", {29'd0, ram_wr, if_rdy, mem_rdy}, 32'd0);
            if (if_rdy && mem_rdy) begin
                fail("both_rdy", "if_rdy and mem_rdy high together");
            end else if (if_rdy || mem_rdy) begin
                if (sb.size() == 0) begin
                    fail("unexpected_rdy", "rdy pulse with nothing outstanding");
                end else begin
                    e = sb.pop_front();
                    chk("rdy_src_if", {31'd0, if_rdy}, {31'd0, e.is_if});
                    chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_load && e.is_if) begin
                        chk("if_data", if_data, e.data);
                        mdl_if_data = e.data;
                    end else if (e.is_load) begin
                        chk("mem_rdata", mem_rdata, e.data);
                        mdl_mem_rdata = e.data;
                    end
                end
            end else if (sb.size() == 0) begin
                chk("if_data_hold", if_data, mdl_if_data);
                chk("mem_rdata_hold", mem_rdata, mdl_mem_rdata);
            end
            if (ram_wr) begin
                if (wq.size() == 0) begin
                    fail("unexpected_write", $sformatf("write %h to %h", ram_dout, ram_a));
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", ram_a, w.a);
                    chk("wr_data", {24'd0, ram_dout}, {24'd0, w.d});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ram_put(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        pre_we = 1'b1;
        pre_a  = a[11:0];
        pre_d  = d;
        ref_mem[a] = d;
        @(posedge clk_in);
        #1 pre_we = 1'b0;
    endtask

    // Mid-operation noise on both ports, using only codes that must read as NOP.
    task automatic scramble();
        logic [1:0] x;
        x = 2'($urandom_range(0, 2));
        if_op     = (x == 2'd1) ? 2'b11 : x;
        mem_op    = $urandom_range(0, 1) ? 2'b11 : MEM_NOP;
        if_len    = 2'($urandom);
        mem_len   = 2'($urandom);
        if_addr   = $urandom;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(posedge clk_in);
            g++;
        end
        if (sb.size() != 0) begin
            fail("rdy_timeout", "expected rdy pulse never arrived");
            sb.delete();
        end
        if (wq.size() != 0) begin
            fail("missing_writes", $sformatf("%0d RAM writes never seen", wq.size()));
            wq.delete();
        end
    endtask

    // Build expectations for one request from the shadow memory, then run it.
    function automatic exp_t expect_req(input bit is_if, input logic [1:0] op, input logic [1:0] len,
                                        input logic [31:0] addr, input logic [31:0] wd, input int c);
        exp_t e;
        wr_t  w;
        int   n = nbytes(len);
        e.is_if   = is_if;
        e.is_load = is_if || (op == MEM_LOAD);
        e.data    = '0;
        if (e.is_load) begin
            for (int k = 0; k < n; k++)
                e.data = e.data | (32'(ref_rd(addr + 32'(k))) << (8 * k));
            e.cyc = c + n + 2;
        end else begin
            for (int k = 0; k < n; k++) begin
                w.a = addr + 32'(k);
                w.d = 8'(wd >> (8 * k));
                ref_mem[w.a] = w.d;
                wq.push_back(w);
            end
            e.cyc = c + n + 1;
        end
        return e;
    endfunction

    task automatic do_req(input bit is_if, input logic [1:0] op, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wd, input int st_at, input int st_len);
        exp_t e;
        int   n = nbytes(len);
        @(negedge clk_in);
        if (is_if) begin
            if_op = MEM_LOAD; if_len = len; if_addr = addr; mem_op = MEM_NOP;
        end else begin
            mem_op = op; mem_len = len; mem_addr = addr; mem_wdata = wd; if_op = MEM_NOP;
        end
        e = expect_req(is_if, op, len, addr, wd, cyc);
        e.cyc += st_len;
        sb.push_back(e);
        for (int t = 1; t <= n + 2 + st_len; t++) begin
            @(posedge clk_in);
            #1;
            scramble();
            if (st_len > 0 && t == st_at) rdy_in = 1'b0;
            if (st_len > 0 && t == st_at + st_len) rdy_in = 1'b1;
            if (st_len == 0 && t <= n) chk("ram_a_seq", ram_a, addr + 32'(t - 1));
        end
        rdy_in = 1'b1;
        wait_drain();
    endtask

    initial begin
        exp_t e;
        int   c;
        // Reset and preload
        ram_put(32'h100, 8'h11); ram_put(32'h101, 8'h22);
        ram_put(32'h102, 8'h33); ram_put(32'h103, 8'h44);
        ram_put(32'hFFFF_FFFF, 8'h01); ram_put(32'h0, 8'h02);
        @(negedge clk_in);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_flags", {29'd0, ram_wr, if_rdy, mem_rdy}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst_in = 1'b1;

        do_req(1'b1, MEM_LOAD, MEM_WORD, 32'h100, 32'd0, 0, 0);
        do_req(1'b0, MEM_STORE, MEM_WORD, 32'h200, 32'hDEAD_BEEF, 0, 0);
        do_req(1'b0, MEM_LOAD, MEM_BYTE, 32'h202, 32'd0, 0, 0);

        // Fetch and MEM load collide: MEM first, fetch accepted in the IDLE after MEM's DONE.
        @(negedge clk_in);
        if_op = MEM_LOAD; if_len = MEM_WORD; if_addr = 32'h100;
        mem_op = MEM_LOAD; mem_len = MEM_HALF; mem_addr = 32'h200;
        c = cyc;
        sb.push_back(expect_req(1'b0, MEM_LOAD, MEM_HALF, 32'h200, 32'd0, c));
        e = expect_req(1'b1, MEM_LOAD, MEM_WORD, 32'h100, 32'd0, c + 5);
        sb.push_back(e);
        @(posedge clk_in);
        #1 mem_op = MEM_NOP;
        while (cyc < c + 6) begin
            @(posedge clk_in);
            #1;
        end
        if_op = MEM_NOP;
        wait_drain();

        do_req(1'b0, MEM_LOAD, MEM_HALF, 32'hFFFF_FFFF, 32'd0, 0, 0);
        do_req(1'b0, MEM_LOAD, MEM_WORD, 32'h100, 32'd0, 3, 3);
        do_req(1'b1, MEM_LOAD, MEM_WORD, 32'h100, 32'd0, 6, 3);
        do_req(1'b0, MEM_STORE, MEM_WORD, 32'h208, 32'h1234_5678, 2, 2);
        do_req(1'b0, MEM_LOAD, MEM_WORD, 32'h208, 32'd0, 0, 0);

        // Reset during WRITE step 2 of a word store.
        @(negedge clk_in);
        mem_op = MEM_STORE; mem_len = MEM_WORD; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
        c = cyc;
        e = expect_req(1'b0, MEM_STORE, MEM_WORD, 32'h300, 32'hCAFE_F00D, c);
        while (cyc < c + 3) begin
            @(posedge clk_in);
            #1 mem_op = MEM_NOP;
        end
        chk("abort_wr_live", {31'd0, ram_wr}, 32'd1);
        chk("abort_ram_a", ram_a, 32'h302);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        wq.delete();
        mdl_if_data = '0;
        mdl_mem_rdata = '0;
        chk("abort_ram_a0", ram_a, 32'd0);
        chk("abort_dout0", {24'd0, ram_dout}, 32'd0);
        chk("abort_flags0", {29'd0, ram_wr, if_rdy, mem_rdy}, 32'd0);
        chk("abort_if_data0", if_data, 32'd0);
        chk("abort_mem_rdata0", mem_rdata, 32'd0);
        do_req(1'b1, MEM_LOAD, MEM_WORD, 32'h100, 32'd0, 0, 0);

        // Randomized traffic over a small window and the top-of-memory wrap.
        for (int i = 0; i < 40; i++) begin
            bit          is_if = 1'($urandom_range(0, 2) == 0);
            logic [1:0]  op    = $urandom_range(0, 1) ? MEM_STORE : MEM_LOAD;
            logic [1:0]  len   = 2'($urandom);
            logic [31:0] addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                              : 32'h400 + 32'($urandom_range(0, 63));
            int          n     = nbytes(len);
            int          st_len = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            int          st_at;
            if (is_if) op = MEM_LOAD;
            st_at = int'($urandom_range(1, (op == MEM_LOAD) ? n + 2 : n + 1));
            do_req(is_if, op, len, addr, $urandom, st_at, st_len);
        end

        repeat (3) @(posedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
